// File: rtl/vpu3_ctrl.sv
// vpu3_ctrl: sequencer streaming len operands from banks A/B/C through the fixed-latency datapath into the result bank
//   Parameters: AWIDTH (address width), LWIDTH (length width), RD_LATENCY (SRAM read latency), DP_LATENCY (datapath latency)
//   Inputs : clk, rst_n (async, active-low), i_start, i_len, i_rd_base, i_wr_base, i_hold, i_dp_dout_vld (spare)
//   Outputs: o_busy, o_done, o_rd_en, o_rd_addr, o_dp_vld, o_wr_en, o_wr_addr, o_cycle_cnt
//   Build option: define VPU3_CTRL_PERF_EN to enable the saturating busy-cycle counter on o_cycle_cnt
module vpu3_ctrl #(
  parameter int AWIDTH     = 10,
  parameter int LWIDTH     = 11,
  parameter int RD_LATENCY = 1,
  parameter int DP_LATENCY = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [LWIDTH-1:0] i_len,
  input  logic [AWIDTH-1:0] i_rd_base,
  input  logic [AWIDTH-1:0] i_wr_base,
  input  logic              i_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [AWIDTH-1:0] o_rd_addr,
  output logic              o_dp_vld,
  input  logic              i_dp_dout_vld,
  output logic              o_wr_en,
  output logic [AWIDTH-1:0] o_wr_addr,
  output logic [31:0]       o_cycle_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [LWIDTH-1:0] r_len, r_issued, r_written;
  logic [AWIDTH-1:0] r_rd_addr, r_wr_addr;
  logic [RD_LATENCY-1:0] r_rd_sr;
  logic [DP_LATENCY-1:0] r_dp_sr;
  logic w_start, w_last_rd, w_last_wr, w_unused;
  assign w_unused  = i_dp_dout_vld;
  assign w_start   = (r_state == S_IDLE) && i_start;
  assign w_last_rd = o_rd_en && (r_issued == r_len - LWIDTH'(1));
  assign w_last_wr = o_wr_en && (r_written == r_len - LWIDTH'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (i_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last_rd) w_next = S_DRAIN;
      S_DRAIN: if (w_last_wr) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // the read strobe follows i_hold in the same cycle so a bubble costs exactly one slot
  always_comb begin
    o_busy  = (r_state == S_RUN) || (r_state == S_DRAIN);
    o_done  = r_state == S_DONE;
    o_rd_en = (r_state == S_RUN) && !i_hold;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_len     <= '0;
      r_issued  <= '0;
      r_written <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_rd_sr   <= '0;
      r_dp_sr   <= '0;
    end else begin
      if (w_start) begin
        r_len     <= i_len;
        r_issued  <= '0;
        r_written <= '0;
        r_rd_addr <= i_rd_base;
        r_wr_addr <= i_wr_base;
      end else begin
        if (o_rd_en) begin
          r_issued  <= r_issued + LWIDTH'(1);
          r_rd_addr <= r_rd_addr + AWIDTH'(1);
        end
        if (o_wr_en) begin
          r_written <= r_written + LWIDTH'(1);
          r_wr_addr <= r_wr_addr + AWIDTH'(1);
        end
      end
      r_rd_sr[0] <= o_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) r_rd_sr[i] <= r_rd_sr[i-1];
      r_dp_sr[0] <= r_rd_sr[RD_LATENCY-1];
      for (int i = 1; i < DP_LATENCY; i++) r_dp_sr[i] <= r_dp_sr[i-1];
    end
  assign o_rd_addr = r_rd_addr;
  assign o_wr_addr = r_wr_addr;
  assign o_dp_vld  = r_rd_sr[RD_LATENCY-1];
  assign o_wr_en   = r_dp_sr[DP_LATENCY-1];
`ifdef VPU3_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                       r_cycle_cnt <= '0;
    else if (w_start)                 r_cycle_cnt <= '0;
    else if (o_busy && ~&r_cycle_cnt) r_cycle_cnt <= r_cycle_cnt + 32'(1);
  assign o_cycle_cnt = r_cycle_cnt;
`else
  assign o_cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_vpu3_ctrl.sv
// tb_vpu3_ctrl: randomized scoreboard bench for vpu3_ctrl
module tb_vpu3_ctrl;
  localparam int AW = 10, LW = 11, RD = 1, DP = 8;
  logic clk = 0, rst_n = 0, i_start = 0, i_hold = 0, i_dp_dout_vld = 0;
  logic [LW-1:0] i_len = '0;
  logic [AW-1:0] i_rd_base = '0, i_wr_base = '0;
  logic o_busy, o_done, o_rd_en, o_dp_vld, o_wr_en;
  logic [AW-1:0] o_rd_addr, o_wr_addr;
  logic [31:0] o_cycle_cnt;
  vpu3_ctrl #(.AWIDTH(AW), .LWIDTH(LW), .RD_LATENCY(RD), .DP_LATENCY(DP)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len), .i_rd_base(i_rd_base),
    .i_wr_base(i_wr_base), .i_hold(i_hold), .o_busy(o_busy), .o_done(o_done),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_dp_vld(o_dp_vld),
    .i_dp_dout_vld(i_dp_dout_vld), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_cycle_cnt(o_cycle_cnt));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int c; logic [AW-1:0] a;} ev_t;
  ev_t rd_q[$], wr_q[$];
  int dp_q[$], done_q[$];
  int tests = 0, fails = 0;
  int busy_lo = 1, busy_hi = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic extra(input string name);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event, got 1 expected 0 (cycle %0d)", name, cyc);
  endtask
  always @(negedge clk) if (rst_n) begin
    ev_t e;
    int c;
    chk("busy", o_busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    if (o_rd_en) begin
      if (rd_q.size() == 0) extra("rd_en");
      else begin
        e = rd_q.pop_front();
        chk("rd_cycle", cyc, e.c);
        chk("rd_addr", o_rd_addr, e.a);
      end
    end
    if (o_dp_vld) begin
      if (dp_q.size() == 0) extra("dp_vld");
      else begin
        c = dp_q.pop_front();
        chk("dp_cycle", cyc, c);
      end
    end
    if (o_wr_en) begin
      if (wr_q.size() == 0) extra("wr_en");
      else begin
        e = wr_q.pop_front();
        chk("wr_cycle", cyc, e.c);
        chk("wr_addr", o_wr_addr, e.a);
      end
    end
    if (o_done) begin
      if (done_q.size() == 0) extra("done");
      else begin
        c = done_q.pop_front();
        chk("done_cycle", cyc, c);
      end
    end
  end
  // hmode: 0 no hold, 1 random holds, 2 hold in the 2nd RUN cycle; poke: spurious starts while busy
  task automatic run_cmd(input int len, input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                         input int hmode, input bit poke, input int rst_off);
    bit plan[$];
    int c0, n, k, lastw, donec, endc;
    bit h, was_rst;
    @(posedge clk); #1;
    c0 = cyc;
    i_start = 1; i_hold = 0;
    i_len = LW'(len); i_rd_base = rb; i_wr_base = wb;
    n = 0; k = 0; lastw = c0;
    while (n < len) begin
      h = (hmode == 1) ? ($urandom_range(0, 2) == 0) : (hmode == 2) ? (k == 1) : 1'b0;
      plan.push_back(h);
      if (!h) begin
        rd_q.push_back('{c0 + 1 + k, AW'(rb + n)});
        dp_q.push_back(c0 + 1 + k + RD);
        wr_q.push_back('{c0 + 1 + k + RD + DP, AW'(wb + n)});
        lastw = c0 + 1 + k + RD + DP;
        n++;
      end
      k++;
    end
    donec = (len == 0) ? c0 + 1 : lastw + 1;
    done_q.push_back(donec);
    busy_lo = (len == 0) ? 1 : c0 + 1;
    busy_hi = (len == 0) ? 0 : lastw;
    endc = donec + 2;
    was_rst = 0;
    @(posedge clk); #1;
    for (int c = c0 + 1; c <= endc; c++) begin
      i_start = poke && c <= lastw && ($urandom_range(0, 3) == 0);
      if (i_start) begin
        i_len = LW'($urandom_range(0, 30)); i_rd_base = AW'($urandom); i_wr_base = AW'($urandom);
      end
      i_hold = (c - c0 - 1 < plan.size()) ? plan[c - c0 - 1] : ($urandom_range(0, 1) == 1);
      if (rst_off > 0 && c == c0 + rst_off) begin
        rst_n = 0;
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_dp_vld", o_dp_vld, 0);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_rd_addr", o_rd_addr, 0);
        chk("rst_wr_addr", o_wr_addr, 0);
        chk("rst_cycle_cnt", o_cycle_cnt, 0);
        rd_q.delete(); wr_q.delete(); dp_q.delete(); done_q.delete();
        busy_lo = 1; busy_hi = 0;
        i_start = 0; i_hold = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        repeat (14) @(posedge clk);
        #1;
        was_rst = 1;
        break;
      end
      @(posedge clk); #1;
    end
    i_start = 0; i_hold = 0;
    chk("rd_pending", rd_q.size(), 0);
    chk("dp_pending", dp_q.size(), 0);
    chk("wr_pending", wr_q.size(), 0);
    chk("done_pending", done_q.size(), 0);
    chk("busy_after", o_busy, 0);
`ifdef VPU3_CTRL_PERF_EN
    if (!was_rst) chk("cycle_cnt", o_cycle_cnt, (len == 0) ? 0 : lastw - c0);
`else
    chk("cycle_cnt", o_cycle_cnt, 0);
`endif
  endtask
  initial begin
    #12;
    chk("init_busy", o_busy, 0);
    chk("init_done", o_done, 0);
    chk("init_rd_en", o_rd_en, 0);
    chk("init_wr_en", o_wr_en, 0);
    chk("init_rd_addr", o_rd_addr, 0);
    chk("init_wr_addr", o_wr_addr, 0);
    chk("init_cycle_cnt", o_cycle_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1;
    run_cmd(4, 10'h010, 10'h200, 0, 0, 0);
    run_cmd(0, 10'h055, 10'h066, 0, 0, 0);
    run_cmd(3, 10'h020, 10'h120, 2, 0, 0);
    run_cmd(6, 10'h100, 10'h300, 0, 1, 0);
    run_cmd(3, 10'h3FE, 10'h3FF, 0, 0, 0);
    run_cmd(8, 10'h040, 10'h080, 0, 0, 12);
    run_cmd(2, 10'h005, 10'h006, 0, 0, 0);
    for (int t = 0; t < 12; t++)
      run_cmd($urandom_range(1, 20), AW'($urandom), AW'($urandom), 1, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
